// File: rtl/transmisor_dac_spi_pkg.sv
// Shared constants and state encoding for the SPI DAC transmitter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package transmisor_dac_spi_pkg;

    // Every DAC121S101-style frame is 16 bits.
    localparam int FRAME_BITS   = 16;
    // Two SCLK half-periods per transmitted bit.
    localparam int HALF_PERIODS = 2 * FRAME_BITS;
    // Fill value for the bits above the code. Zero selects normal (powered-up) mode.
    localparam logic PD_NORMAL  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } estado_t;

endpackage

// File: rtl/transmisor_dac_spi_conv_codigo_dac.sv
// Signed fixed-point sample to saturated offset-binary DAC code.
// Latency: combinational.
// Backpressure: none.
module conv_codigo_dac #(
    parameter int N        = 25,
    parameter int FRAC     = 16,
    parameter int DAC_BITS = 12
) (
    input  logic [N-1:0]        yk,
    output logic [DAC_BITS-1:0] code
);

    // Lowest sample bit that survives truncation.
    localparam int LSB = FRAC - DAC_BITS + 1;

    logic en_rango;
    // Bits below the DAC resolution are truncated away on purpose.
    logic unused_lsb;
    assign unused_lsb = ^yk[LSB-1:0];

    // In range when the integer part is pure sign extension; otherwise clip to the rail.
    always_comb begin
        en_rango = (yk[N-1:FRAC] == {(N-FRAC){yk[N-1]}});
        code     = '0;
        if (en_rango) begin
            code = {~yk[FRAC], yk[FRAC-1:LSB]};
        end else if (yk[N-1]) begin
            code = '0;
        end else begin
            code = '1;
        end
    end

endmodule

// File: rtl/transmisor_dac_spi.sv
// Serialises each filtered sample as a 16-bit SPI frame for the external DAC.
// Latency: strobe at cycle t gives DAC_SYNC low at t+2; the frame lasts 32*DIV cycles, then GAP_CYC cycles of gap.
// Backpressure: none; a sample arriving while busy waits in a one-entry buffer, the newest wins, and Desborde flags the overwrite.
module transmisor_dac_spi #(
    parameter int N        = 25,
    parameter int FRAC     = 16,
    parameter int DAC_BITS = 12,
    parameter int DIV      = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] Yk,
    input  logic         Bandera_Listo,
    output logic         DAC_SYNC,
    output logic         DAC_SCLK,
    output logic         DAC_DIN,
    output logic         Ocupado,
    output logic         Listo_DAC,
    output logic         Desborde
);

    import transmisor_dac_spi_pkg::*;

    localparam int PAD = FRAME_BITS - DAC_BITS;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int KW  = $clog2(HALF_PERIODS);

    estado_t                 estado;
    logic [DAC_BITS-1:0]     code_conv;
    logic [DAC_BITS-1:0]     pend_code;
    logic                    pend_vld;
    logic [FRAME_BITS-1:0]   trama;
    logic [KW-1:0]           k;
    logic [DW-1:0]           div_cnt;
    logic [GW-1:0]           gap_cnt;

    // One converter serves both the direct capture and the pending buffer,
    // since both take their code from the same Yk input.
    conv_codigo_dac #(
        .N        (N),
        .FRAC     (FRAC),
        .DAC_BITS (DAC_BITS)
    ) u_conv (
        .yk   (Yk),
        .code (code_conv)
    );

    function automatic logic [FRAME_BITS-1:0] arma_trama(input logic [DAC_BITS-1:0] c);
        return {{PAD{PD_NORMAL}}, c};
    endfunction

    // Frame sequencer. trama is shifted left so the next bit is always trama[MSB].
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado    <= IDLE;
            pend_vld  <= 1'b0;
            pend_code <= '0;
            trama     <= '0;
            k         <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            DAC_SYNC  <= 1'b1;
            DAC_SCLK  <= 1'b1;
            DAC_DIN   <= 1'b0;
            Ocupado   <= 1'b0;
            Listo_DAC <= 1'b0;
            Desborde  <= 1'b0;
        end else begin
            Listo_DAC <= 1'b0;
            Desborde  <= 1'b0;

            // Samples arriving while busy go to the pending slot; the GAP branch
            // below may consume the slot in the same cycle.
            if (Bandera_Listo && estado != IDLE) begin
                pend_code <= code_conv;
                pend_vld  <= 1'b1;
                if (pend_vld) begin
                    Desborde <= 1'b1;
                end
            end

            case (estado)
                IDLE: begin
                    Ocupado <= Bandera_Listo;
                    if (Bandera_Listo) begin
                        trama  <= arma_trama(code_conv);
                        estado <= LOAD;
                    end
                end

                LOAD: begin
                    DAC_SYNC <= 1'b0;
                    DAC_SCLK <= 1'b1;
                    DAC_DIN  <= trama[FRAME_BITS-1];
                    trama    <= {trama[FRAME_BITS-2:0], 1'b0};
                    k        <= '0;
                    div_cnt  <= '0;
                    estado   <= SHIFT;
                end

                SHIFT: begin
                    if (div_cnt == DW'(DIV - 1)) begin
                        div_cnt <= '0;
                        if (k == KW'(HALF_PERIODS - 1)) begin
                            DAC_SYNC <= 1'b1;
                            DAC_SCLK <= 1'b1;
                            DAC_DIN  <= 1'b0;
                            gap_cnt  <= '0;
                            estado   <= GAP;
                        end else begin
                            k <= k + 1'b1;
                            // Leaving an odd half-period means SCLK rises and the next bit is presented.
                            DAC_SCLK <= k[0];
                            if (k[0]) begin
                                DAC_DIN <= trama[FRAME_BITS-1];
                                trama   <= {trama[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        Listo_DAC <= 1'b1;
                        // A strobe on this very cycle is newer than any pending code.
                        if (Bandera_Listo) begin
                            trama    <= arma_trama(code_conv);
                            pend_vld <= 1'b0;
                            estado   <= LOAD;
                        end else if (pend_vld) begin
                            trama    <= arma_trama(pend_code);
                            pend_vld <= 1'b0;
                            estado   <= LOAD;
                        end else begin
                            estado <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transmisor_dac_spi.sv
// Self-checking bench for transmisor_dac_spi: SPI frame decoder, directed vectors,
// timing sequences and a randomized run against a cycle-arithmetic reference model.
module tb_transmisor_dac_spi;

    localparam int N        = 25;
    localparam int FRAC     = 16;
    localparam int DAC_BITS = 12;
    localparam int DIV      = 2;
    localparam int GAP_CYC  = 2;
    // Cycles between consecutive back-to-back frame acceptances.
    localparam int P        = 32 * DIV + GAP_CYC + 1;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] Yk = '0;
    logic         Bandera_Listo = 1'b0;
    logic         DAC_SYNC, DAC_SCLK, DAC_DIN, Ocupado, Listo_DAC, Desborde;

    transmisor_dac_spi #(
        .N(N), .FRAC(FRAC), .DAC_BITS(DAC_BITS), .DIV(DIV), .GAP_CYC(GAP_CYC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Yk(Yk), .Bandera_Listo(Bandera_Listo),
        .DAC_SYNC(DAC_SYNC), .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN),
        .Ocupado(Ocupado), .Listo_DAC(Listo_DAC), .Desborde(Desborde)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // DAC-side decoder: shifts DIN on every SCLK fall while SYNC is low.
    logic        mon_en = 1'b0;
    logic        sync_prev = 1'b1, sclk_prev = 1'b1;
    logic [15:0] sh = '0;
    int          nbits = 0, lowc = 0, bad = 0, n_listo = 0, n_desb = 0;
    logic [15:0] rx_q[$];
    int          low_q[$];
    int          fall_q[$];

    always @(negedge Clk) begin
        if (mon_en) begin
            if (sync_prev && !DAC_SYNC) begin
                nbits = 0; lowc = 0; sh = '0;
                fall_q.push_back(cyc);
            end
            if (!DAC_SYNC) begin
                lowc++;
                if (sclk_prev && !DAC_SCLK) begin
                    sh = {sh[14:0], DAC_DIN};
                    nbits++;
                end
            end
            if (!sync_prev && DAC_SYNC) begin
                if (nbits == 16) begin
                    rx_q.push_back(sh);
                    low_q.push_back(lowc);
                end else begin
                    bad++;
                end
            end
            if (Listo_DAC) n_listo++;
            if (Desborde)  n_desb++;
            sync_prev = DAC_SYNC;
            sclk_prev = DAC_SCLK;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference conversion by plain arithmetic on the sample's real value.
    function automatic logic [15:0] ref_frame(input logic [N-1:0] y);
        logic signed [N-1:0] s;
        int v, c;
        s = y;
        v = s;
        if (v >= (1 << FRAC))       c = (1 << DAC_BITS) - 1;
        else if (v < -(1 << FRAC))  c = 0;
        else                        c = (v + (1 << FRAC)) >> (FRAC - DAC_BITS + 1);
        return 16'(c);
    endfunction

    function automatic longint rx_at(input int i);
        if (rx_q.size() > i) return longint'(rx_q[i]);
        return -1;
    endfunction

    // Strobe sampled at the edge after the first negedge; returns one cycle later.
    task automatic strobe(input logic [N-1:0] v);
        @(negedge Clk);
        Yk = v;
        Bandera_Listo = 1'b1;
        @(negedge Clk);
        Bandera_Listo = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string nm);
        int b;
        b = 0;
        while (rx_q.size() < n && b < budget) begin
            @(negedge Clk);
            b++;
        end
        chk({nm, " frames"}, rx_q.size(), n);
    endtask

    typedef struct {
        logic [N-1:0] yk;
        logic [15:0]  frame;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sy[0:71];
        logic oc[0:71];
        logic li[0:71];
        int first_low, nlow, li_at, li_cnt, oc_last, oc_cnt;
        int d0, l0, b0, ed, t_acc, i;
        logic act, pv, s;
        logic [N-1:0] pval, v;
        logic [15:0] exp_q[$];

        vecs[0] = '{25'h0000000, 16'h0800};
        vecs[1] = '{25'h0008000, 16'h0C00};
        vecs[2] = '{25'h1FF0000, 16'h0000};
        vecs[3] = '{25'h0010000, 16'h0FFF};
        vecs[4] = '{25'h1000000, 16'h0000};
        vecs[5] = '{25'h0FFFFFF, 16'h0FFF};
        vecs[6] = '{25'h1FF8000, 16'h0400};
        vecs[7] = '{25'h000FFFF, 16'h0FFF};
        vecs[8] = '{25'h1FEFFFF, 16'h0000};
        vecs[9] = '{25'h0000020, 16'h0801};

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset SYNC", DAC_SYNC, 1);
        chk("reset SCLK", DAC_SCLK, 1);
        chk("reset DIN", DAC_DIN, 0);
        chk("reset Ocupado", Ocupado, 0);
        chk("reset Listo_DAC", Listo_DAC, 0);
        chk("reset Desborde", Desborde, 0);
        Reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge Clk);

        // Single frame timing for Yk = 0
        rx_q.delete();
        strobe(25'h0);
        sy[0] = 1'b1; oc[0] = 1'b0; li[0] = 1'b0;
        sy[1] = DAC_SYNC; oc[1] = Ocupado; li[1] = Listo_DAC;
        chk("t1 SCLK idle before frame", DAC_SCLK, 1);
        for (int j = 2; j <= 71; j++) begin
            @(negedge Clk);
            sy[j] = DAC_SYNC; oc[j] = Ocupado; li[j] = Listo_DAC;
            if (j == 2)  chk("t1 first DIN", DAC_DIN, 0);
            if (j == 66) chk("t1 DIN after frame", DAC_DIN, 0);
        end
        first_low = -1; nlow = 0; li_at = -1; li_cnt = 0; oc_last = -1; oc_cnt = 0;
        for (int j = 0; j <= 71; j++) begin
            if (!sy[j]) begin
                nlow++;
                if (first_low < 0) first_low = j;
            end
            if (li[j]) begin li_cnt++; li_at = j; end
            if (oc[j]) begin oc_cnt++; oc_last = j; end
        end
        chk("t1 SYNC fall cycle", first_low, 2);
        chk("t1 SYNC low cycles", nlow, 32 * DIV);
        chk("t1 Listo_DAC cycle", li_at, 2 + 32 * DIV + GAP_CYC);
        chk("t1 Listo_DAC count", li_cnt, 1);
        chk("t1 Ocupado last", oc_last, 2 + 32 * DIV + GAP_CYC);
        chk("t1 Ocupado count", oc_cnt, 1 + 32 * DIV + GAP_CYC + 1);
        chk("t1 frame", rx_at(0), 16'h0800);

        // Conversion table
        foreach (vecs[n]) begin
            rx_q.delete();
            low_q.delete();
            strobe(vecs[n].yk);
            wait_rx(1, 300, $sformatf("vec%0d", n));
            chk($sformatf("vec%0d frame", n), rx_at(0), vecs[n].frame);
            chk($sformatf("vec%0d SYNC low", n), (low_q.size() > 0) ? low_q[0] : -1, 32 * DIV);
            repeat (6) @(negedge Clk);
        end

        // Second strobe while busy is sent right after the first gap
        rx_q.delete(); fall_q.delete(); d0 = n_desb;
        strobe(25'h0008000);
        repeat (8) @(negedge Clk);
        strobe(25'h0);
        wait_rx(2, 400, "t4");
        chk("t4 frame0", rx_at(0), 16'h0C00);
        chk("t4 frame1", rx_at(1), 16'h0800);
        chk("t4 frame spacing", (fall_q.size() > 1) ? fall_q[1] - fall_q[0] : -1, P);
        chk("t4 Desborde count", n_desb - d0, 0);
        repeat (6) @(negedge Clk);

        // Three strobes in one frame: middle one is dropped
        rx_q.delete(); d0 = n_desb;
        strobe(25'h1FF8000);
        repeat (3) @(negedge Clk);
        strobe(25'h0004000);
        chk("t5 no Desborde on B", Desborde, 0);
        repeat (3) @(negedge Clk);
        strobe(25'h1FFC000);
        chk("t5 Desborde on C", Desborde, 1);
        wait_rx(2, 400, "t5");
        repeat (200) @(negedge Clk);
        chk("t5 total frames", rx_q.size(), 2);
        chk("t5 frame A", rx_at(0), 16'h0400);
        chk("t5 frame C", rx_at(1), 16'h0600);
        chk("t5 Desborde count", n_desb - d0, 1);

        // Reset in the middle of SHIFT (k = 13)
        rx_q.delete(); b0 = bad;
        strobe(25'h0008000);
        repeat (27) @(negedge Clk);
        Reset = 1'b1;
        Yk = 25'h0000020;
        Bandera_Listo = 1'b1;
        @(negedge Clk);
        chk("t6 SYNC after reset", DAC_SYNC, 1);
        chk("t6 SCLK after reset", DAC_SCLK, 1);
        chk("t6 DIN after reset", DAC_DIN, 0);
        chk("t6 Ocupado after reset", Ocupado, 0);
        Reset = 1'b0;
        Bandera_Listo = 1'b0;
        @(negedge Clk);
        chk("t6 strobe during reset ignored", Ocupado, 0);
        chk("t6 aborted frame", bad - b0, 1);
        repeat (4) @(negedge Clk);
        strobe(25'h1FF8000);
        wait_rx(1, 300, "t6");
        chk("t6 frame after reset", rx_at(0), 16'h0400);
        repeat (6) @(negedge Clk);

        // Randomized traffic against a cycle-arithmetic model
        rx_q.delete(); d0 = n_desb; l0 = n_listo;
        act = 1'b0; pv = 1'b0; pval = '0; ed = 0; t_acc = 0; i = 0;
        while ((i < 1500 || act) && i < 5000) begin
            @(negedge Clk);
            s = (i < 1500) && ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1) == 1) v = N'($urandom_range(0, 131071)) - N'(65536);
            else                           v = N'($urandom);
            Bandera_Listo = s;
            Yk = v;
            if (act && i == t_acc + P) begin
                if (s) begin
                    if (pv) ed++;
                    pval = v; pv = 1'b1;
                end
                if (pv) begin
                    t_acc = i;
                    exp_q.push_back(ref_frame(pval));
                    pv = 1'b0;
                end else begin
                    act = 1'b0;
                end
            end else if (act) begin
                if (s) begin
                    if (pv) ed++;
                    pval = v; pv = 1'b1;
                end
            end else if (s) begin
                act = 1'b1;
                t_acc = i;
                exp_q.push_back(ref_frame(v));
            end
            i++;
        end
        @(negedge Clk);
        Bandera_Listo = 1'b0;
        wait_rx(exp_q.size(), 2000, "rand");
        repeat (100) @(negedge Clk);
        chk("rand frame count", rx_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            chk($sformatf("rand frame %0d", j), rx_at(j), exp_q[j]);
        chk("rand Desborde count", n_desb - d0, ed);
        chk("rand Listo_DAC count", n_listo - l0, exp_q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
